// File: rtl/cache_pkg.sv
// Shared cache definitions: store/load mode encodings, store-merge FSM states, widths.
package cache_pkg;
  localparam int WORD_BITS     = 32;
  localparam int LINE_BITS_DEF = 512;

  localparam logic [2:0] MODE_SW = 3'b000;
  localparam logic [2:0] MODE_SH = 3'b001;
  localparam logic [2:0] MODE_SB = 3'b010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HIT_WR  = 2'd1,
    REFILL  = 2'd2,
    LINE_WR = 2'd3
  } smuState_t;
endpackage

// File: rtl/store_align.sv
// Store lane alignment: byte enables, lane-replicated data, illegal/misalign flags.
// STORE_MISALIGN_CHECK_EN enables the misalign flag; otherwise it is tied low.
module store_align
  import cache_pkg::*;
(
  input  logic [2:0]           mode,
  input  logic [1:0]           offLo,
  input  logic [WORD_BITS-1:0] wData,
  output logic [3:0]           byteEn,
  output logic [WORD_BITS-1:0] repData,
  output logic                 illegal,
  output logic                 misalign
);
  always_comb begin
    byteEn   = 4'b0000;
    repData  = '0;
    illegal  = 1'b0;
    misalign = 1'b0;
    case (mode)
      MODE_SW: begin
        byteEn  = 4'b1111;
        repData = wData;
`ifdef STORE_MISALIGN_CHECK_EN
        misalign = (offLo != 2'b00);
`endif
      end
      MODE_SH: begin
        byteEn  = offLo[1] ? 4'b1100 : 4'b0011;
        repData = {2{wData[15:0]}};
`ifdef STORE_MISALIGN_CHECK_EN
        misalign = offLo[0];
`endif
      end
      MODE_SB: begin
        byteEn  = 4'b0001 << offLo;
        repData = {4{wData[7:0]}};
      end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/store_merge_unit.sv
// Store path: word write on hit, refill + line merge + full-line write on miss.
// STORE_MISALIGN_CHECK_EN rejects misaligned sw/sh stores (handled in store_align).
module store_merge_unit
  import cache_pkg::*;
#(
  parameter  int LINE_BITS   = LINE_BITS_DEF,
  localparam int OFFSET_BITS = $clog2(LINE_BITS/8)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   storeValid,
  output logic                   storeReady,
  input  logic [2:0]             mode,
  input  logic [OFFSET_BITS-1:0] offset,
  input  logic [31:0]            wData,
  input  logic                   writeHit,
  output logic                   bankWe,
  output logic [OFFSET_BITS-3:0] bankWordSel,
  output logic [3:0]             bankByteEn,
  output logic [31:0]            bankWData,
  output logic                   memReq,
  input  logic                   fillValid,
  input  logic [LINE_BITS-1:0]   fillLine,
  output logic                   lineWe,
  output logic [LINE_BITS-1:0]   lineData,
  output logic                   storeErr
);
  smuState_t state, nextState;
  logic [3:0]           alnBe;
  logic [WORD_BITS-1:0] alnData;
  logic                 alnIllegal, alnMisalign;
  logic                 accept, reject;
  logic [LINE_BITS-1:0] merged;

  store_align uAlign (
    .mode    (mode),
    .offLo   (offset[1:0]),
    .wData   (wData),
    .byteEn  (alnBe),
    .repData (alnData),
    .illegal (alnIllegal),
    .misalign(alnMisalign)
  );

  assign storeReady = (state == IDLE) && rst_n;
  assign accept     = storeValid && storeReady;
  assign reject     = alnIllegal || alnMisalign;

  // Merge uses the captured lanes, so it is valid throughout REFILL.
  always_comb begin
    merged = fillLine;
    for (int b = 0; b < 4; b++)
      if (bankByteEn[b])
        merged[int'(bankWordSel)*WORD_BITS + b*8 +: 8] = bankWData[b*8 +: 8];
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept && !reject) nextState = writeHit ? HIT_WR : REFILL;
      HIT_WR:  nextState = IDLE;
      REFILL:  if (fillValid) nextState = LINE_WR;
      LINE_WR: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      bankWe      <= 1'b0;
      bankWordSel <= '0;
      bankByteEn  <= '0;
      bankWData   <= '0;
      memReq      <= 1'b0;
      lineWe      <= 1'b0;
      lineData    <= '0;
      storeErr    <= 1'b0;
    end else begin
      state    <= nextState;
      bankWe   <= 1'b0;
      lineWe   <= 1'b0;
      storeErr <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (reject) storeErr <= 1'b1;
          else begin
            bankWordSel <= offset[OFFSET_BITS-1:2];
            bankByteEn  <= alnBe;
            bankWData   <= alnData;
            if (writeHit) bankWe <= 1'b1;
            else          memReq <= 1'b1;
          end
        end
        REFILL: if (fillValid) begin
          memReq   <= 1'b0;
          lineWe   <= 1'b1;
          lineData <= merged;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: hit/illegal vector table plus miss, reset, back-to-back sequences.
module tb_store_merge_unit;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         storeValid, storeReady;
  logic [2:0]   mode;
  logic [5:0]   offset;
  logic [31:0]  wData;
  logic         writeHit;
  logic         bankWe;
  logic [3:0]   bankWordSel;
  logic [3:0]   bankByteEn;
  logic [31:0]  bankWData;
  logic         memReq;
  logic         fillValid;
  logic [511:0] fillLine;
  logic         lineWe;
  logic [511:0] lineData;
  logic         storeErr;

  int passCnt = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  store_merge_unit dut (
    .clk(clk), .rst_n(rst_n), .storeValid(storeValid), .storeReady(storeReady),
    .mode(mode), .offset(offset), .wData(wData), .writeHit(writeHit),
    .bankWe(bankWe), .bankWordSel(bankWordSel), .bankByteEn(bankByteEn),
    .bankWData(bankWData), .memReq(memReq), .fillValid(fillValid),
    .fillLine(fillLine), .lineWe(lineWe), .lineData(lineData), .storeErr(storeErr)
  );

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [2:0]  mode;
    logic [5:0]  offset;
    logic [31:0] wData;
    logic        err;
    logic [3:0]  sel;
    logic [3:0]  be;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[8];

  // Present one store at the negedge; it is accepted at the following posedge.
  task automatic issue(input logic [2:0] m, input logic [5:0] o, input logic [31:0] d, input logic h);
    @(negedge clk);
    mode = m; offset = o; wData = d; writeHit = h; storeValid = 1'b1;
    @(posedge clk); #1;
    storeValid = 1'b0;
  endtask

  logic [511:0] expLine;

  initial begin
    rst_n = 1'b0; storeValid = 1'b0; mode = '0; offset = '0; wData = '0;
    writeHit = 1'b0; fillValid = 1'b0; fillLine = '0;

    vecs[0] = '{3'b010, 6'd5,  32'h000000AB, 1'b0, 4'd1,  4'b0010, 32'hABABABAB};
    vecs[1] = '{3'b000, 6'd8,  32'hDEADBEEF, 1'b0, 4'd2,  4'b1111, 32'hDEADBEEF};
    vecs[2] = '{3'b001, 6'd6,  32'hFFFF5678, 1'b0, 4'd1,  4'b1100, 32'h56785678};
    vecs[3] = '{3'b010, 6'd63, 32'h123456C3, 1'b0, 4'd15, 4'b1000, 32'hC3C3C3C3};
    vecs[4] = '{3'b011, 6'd0,  32'h11111111, 1'b1, 4'd0,  4'b0000, 32'h0};
    vecs[5] = '{3'b111, 6'd4,  32'h22222222, 1'b1, 4'd0,  4'b0000, 32'h0};
`ifdef STORE_MISALIGN_CHECK_EN
    vecs[6] = '{3'b000, 6'd2,  32'hCAFEF00D, 1'b1, 4'd0,  4'b0000, 32'h0};
    vecs[7] = '{3'b001, 6'd1,  32'h0000BEEF, 1'b1, 4'd0,  4'b0000, 32'h0};
`else
    vecs[6] = '{3'b000, 6'd2,  32'hCAFEF00D, 1'b0, 4'd0,  4'b1111, 32'hCAFEF00D};
    vecs[7] = '{3'b001, 6'd1,  32'h0000BEEF, 1'b0, 4'd0,  4'b0011, 32'hBEEFBEEF};
`endif

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst storeReady", storeReady, 0);
    chk("rst outputs", {bankWe, lineWe, memReq, storeErr, bankWordSel, bankByteEn, bankWData}, 0);
    chk("rst lineData", lineData, 0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("ready after reset", storeReady, 1);

    // Hit / illegal vector table
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].mode, vecs[i].offset, vecs[i].wData, 1'b1);
      chk($sformatf("v%0d storeErr", i), storeErr, vecs[i].err);
      chk($sformatf("v%0d bankWe", i), bankWe, !vecs[i].err);
      chk($sformatf("v%0d memReq", i), memReq, 0);
      if (!vecs[i].err) begin
        chk($sformatf("v%0d sel", i), bankWordSel, vecs[i].sel);
        chk($sformatf("v%0d be", i), bankByteEn, vecs[i].be);
        chk($sformatf("v%0d data", i), bankWData, vecs[i].data);
        chk($sformatf("v%0d ready busy", i), storeReady, 0);
      end else
        chk($sformatf("v%0d ready err", i), storeReady, 1);
      @(posedge clk); #1;
      chk($sformatf("v%0d pulse end", i), {bankWe, storeErr, lineWe}, 0);
      chk($sformatf("v%0d ready idle", i), storeReady, 1);
    end

    // fillValid while idle is ignored
    @(negedge clk); fillValid = 1'b1; fillLine = '1;
    @(posedge clk); #1;
    chk("idle fill lineWe", lineWe, 0);
    @(negedge clk); fillValid = 1'b0;

    // Miss: sh at offset 62 into an all-ones line, refill delayed two cycles
    issue(3'b001, 6'd62, 32'h00001234, 1'b0);
    chk("miss memReq", memReq, 1);
    chk("miss bankWe", bankWe, 0);
    repeat (2) @(posedge clk);
    #1 chk("miss hold memReq", memReq, 1);
    chk("miss busy", storeReady, 0);
    chk("miss no lineWe", lineWe, 0);
    @(negedge clk); fillValid = 1'b1; fillLine = '1;
    @(posedge clk); #1; fillValid = 1'b0;
    expLine = '1; expLine[511:496] = 16'h1234;
    chk("miss lineWe", lineWe, 1);
    chk("miss lineData", lineData, expLine);
    chk("miss memReq drop", memReq, 0);
    chk("miss ready during lineWe", storeReady, 0);
    @(posedge clk); #1;
    chk("miss lineWe end", lineWe, 0);
    chk("miss ready back", storeReady, 1);

    // Miss: sb at offset 0, fill in the first REFILL cycle
    issue(3'b010, 6'd0, 32'h00000077, 1'b0);
    fillValid = 1'b1; fillLine = '0;
    @(posedge clk); #1; fillValid = 1'b0;
    expLine = '0; expLine[7:0] = 8'h77;
    chk("fast fill lineWe", lineWe, 1);
    chk("fast fill lineData", lineData, expLine);

    // Reset during REFILL
    @(posedge clk);
    issue(3'b000, 6'd12, 32'h55AA55AA, 1'b0);
    chk("rst-miss memReq", memReq, 1);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst-miss memReq drop", memReq, 0);
    @(negedge clk); rst_n = 1'b1;
    #1 chk("rst-miss idle", storeReady, 1);
    @(negedge clk); fillValid = 1'b1; fillLine = '1;
    @(posedge clk); #1;
    chk("rst-miss no lineWe", lineWe, 0);
    @(negedge clk); fillValid = 1'b0;

    // Back-to-back hits with storeValid held high
    @(negedge clk);
    mode = 3'b010; offset = 6'd9; wData = 32'h5A; writeHit = 1'b1; storeValid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b bankWe %0d", k), bankWe, (k % 2) == 0);
      chk($sformatf("b2b ready %0d", k), storeReady, (k % 2) == 1);
    end
    storeValid = 1'b0;
    chk("b2b lanes", {bankWordSel, bankByteEn, bankWData}, {4'd2, 4'b0010, 32'h5A5A5A5A});

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Store-side counterpart of the cache load-extraction path: accepts processor stores (sw/sh/sb) and aligns the data into byte lanes. On a write hit it issues one word write to the data bank. On a write miss it requests the line from main memory and merges the store into the returned 512-bit line, then writes the whole line back. It sits between the processor store port, the cache data banks and the main-memory refill interface.

## Interface
Parameters:
- LINE_BITS, 512, cache line width; OFFSET_BITS = $clog2(LINE_BITS/8) (6 at default)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- storeValid  in  1  store request valid
- storeReady  out  1  unit can accept a store
- mode  in  3  000 sw, 001 sh, 010 sb; all others illegal
- offset  in  OFFSET_BITS  byte offset within line
- wData  in  32  store data, right-justified
- writeHit  in  1  tag hit for this store, valid with storeValid
- bankWe  out  1  one-cycle word write strobe (hit path)
- bankWordSel  out  OFFSET_BITS-2  word index in line
- bankByteEn  out  4  byte-lane enables
- bankWData  out  32  lane-replicated store data
- memReq  out  1  refill request, held until fill
- fillValid  in  1  refill line valid
- fillLine  in  LINE_BITS  refill data from main memory
- lineWe  out  1  one-cycle full-line write strobe (miss path)
- lineData  out  LINE_BITS  merged line
- storeErr  out  1  one-cycle pulse: store rejected

## Operation
- FSM states: IDLE, HIT_WR, REFILL, LINE_WR.
- storeReady = (state==IDLE) && rst_n. A store is accepted when storeValid && storeReady; mode, offset, wData and writeHit are captured on acceptance.
- Byte enables:
  - sw: 4'b1111
  - sh: offset[1] ? 4'b1100 : 4'b0011
  - sb: 4'b0001 << offset[1:0]
- Data replication: sw wData; sh {2{wData[15:0]}}; sb {4{wData[7:0]}}.
- Accepted legal store, writeHit=1: IDLE→HIT_WR. In HIT_WR: bankWe=1, bankWordSel=offset[5:2], byte enables/data as above. Then →IDLE.
- Accepted legal store, writeHit=0: IDLE→REFILL, memReq=1. REFILL holds until fillValid; then →LINE_WR with lineData = fillLine, where the bytes of word offset[5:2] with bankByteEn set are replaced by bankWData. In LINE_WR: lineWe=1. Then →IDLE.
- Illegal mode (≥3'b011): storeErr pulses the cycle after acceptance. No bank/line write, no memReq. Stays IDLE.
- fillValid outside REFILL is ignored.
- fillValid in the first REFILL cycle is accepted.

## Timing
- Reset (rst_n low at a clk edge): state IDLE; storeReady, bankWe, lineWe, memReq, storeErr = 0; bankWordSel, bankByteEn, bankWData, lineData = 0. Any in-flight store is discarded and memReq drops the next cycle.
- All outputs except storeReady are registered.
- Hit latency: bankWe asserts 1 cycle after acceptance. Next acceptance is possible 2 cycles after the previous one.
- Miss: memReq asserts 1 cycle after acceptance. lineWe asserts 1 cycle after the fillValid cycle. storeReady returns the cycle after lineWe.
- bankWe, lineWe and storeErr are never high in the same cycle.

## Configuration
- STORE_MISALIGN_CHECK_EN defined: a misaligned store is rejected like an illegal mode (storeErr pulse, no write, no memReq). Misaligned means sh with offset[0]=1, or sw with offset[1:0]≠0.
- Not defined: low offset bits are ignored. sh uses offset[1] only; sw is word-aligned down. The store proceeds normally.

## Structure
- Shared package cache_pkg holds:
  - mode encodings MODE_SW/MODE_SH/MODE_SB, matching the load path's 000/001/010
  - FSM state enum
  - WORD_BITS=32 and default LINE_BITS
- One combinational sub-module, store_align: mode+offset+wData → byteEn, replicated data, misalign flag. The FSM and line merge stay in store_merge_unit.

## Test plan
- sb, offset=6'd5, wData=32'hAB, writeHit=1 → 1 cycle later: bankWe=1, bankWordSel=1, bankByteEn=4'b0010, bankWData=32'hABABABAB.
- sh, offset=6'd62, wData=32'h1234, writeHit=0, fillLine all 0xFF → memReq next cycle. After fillValid, lineWe=1 and lineData[511:496]=16'h1234 with all other bits 1.
- mode=3'b011 → storeErr pulse 1 cycle after acceptance; no bankWe, no memReq; storeReady stays 1.
- sw, offset=6'd2. With STORE_MISALIGN_CHECK_EN: storeErr pulse, no write. Without it: bankWe with bankWordSel=0 and bankByteEn=4'b1111.
- rst_n low during REFILL → next cycle memReq=0 and state IDLE. A later fillValid produces no lineWe.
- Back-to-back hit stores with storeValid held high → accepted every 2nd cycle; bankWe pulses alternate cycles.
